// File: rtl/seg_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_scanner
// Purpose  : Time-multiplexed 7-segment scanner with anti-ghost blanking,
//            leading-zero suppression, decimal points and per-digit blink.
// Revision : 1.0  initial release
// ============================================================================
module seg_display_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIV          = 500000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_TICKS  = 50
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    blank_lz,
    output logic [7:0]              ss,
    output logic [NUM_DIGITS-1:0]   enables
);

    localparam int c_PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int c_IDX_W   = $clog2(NUM_DIGITS);
    localparam int c_BLANK_W = $clog2(BLANK_CYCLES + 1);
    localparam int c_BLINK_W = $clog2(BLINK_TICKS + 1);

    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(DIV - 1);
    localparam logic [c_IDX_W-1:0]   c_IDX_LAST   = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [c_BLANK_W-1:0] c_BLANK_LAST = c_BLANK_W'(BLANK_CYCLES - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_TICKS - 1);

    typedef enum logic [0:0] {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } state_t;

    state_t                 r_state;
    logic [c_PRESC_W-1:0]   r_presc;
    logic [c_IDX_W-1:0]     r_idx;
    logic [c_BLANK_W-1:0]   r_blank_cnt;
    logic [c_BLINK_W-1:0]   r_blink_cnt;
    logic                   r_blink_phase;

    logic                   w_tick;
    logic [c_IDX_W-1:0]     w_idx_next;
    logic [NUM_DIGITS-1:0]  w_upper_zero;
    logic [3:0]             w_nibble;
    logic                   w_sel_dp;
    logic                   w_sel_blink;
    logic                   w_sel_lz;
    logic [NUM_DIGITS-1:0]  w_en_show;
    logic [6:0]             w_seg_hex;
    logic [7:0]             w_ss_show;

    assign w_tick     = (r_presc == c_PRESC_LAST);
    assign w_idx_next = (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;

    // w_upper_zero[i] is set when digit i and every digit above it are zero
    always_comb begin
        logic w_zero_run;
        w_zero_run   = 1'b1;
        w_upper_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_run      = w_zero_run && (digits[4*i +: 4] == 4'h0);
            w_upper_zero[i] = w_zero_run;
        end
    end

    always_comb begin
        w_nibble    = 4'h0;
        w_sel_dp    = 1'b0;
        w_sel_blink = 1'b0;
        w_sel_lz    = 1'b0;
        w_en_show   = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_nibble     = digits[4*i +: 4];
                w_sel_dp     = dp_mask[i];
                w_sel_blink  = blink_mask[i];
                w_sel_lz     = (i != 0) && blank_lz && w_upper_zero[i];
                w_en_show[i] = 1'b0;
            end
        end
    end

    always_comb begin
        case (w_nibble)
            4'h0:    w_seg_hex = 7'h40;
            4'h1:    w_seg_hex = 7'h79;
            4'h2:    w_seg_hex = 7'h24;
            4'h3:    w_seg_hex = 7'h30;
            4'h4:    w_seg_hex = 7'h19;
            4'h5:    w_seg_hex = 7'h12;
            4'h6:    w_seg_hex = 7'h02;
            4'h7:    w_seg_hex = 7'h78;
            4'h8:    w_seg_hex = 7'h00;
            4'h9:    w_seg_hex = 7'h10;
            4'hA:    w_seg_hex = 7'h08;
            4'hB:    w_seg_hex = 7'h03;
            4'hC:    w_seg_hex = 7'h46;
            4'hD:    w_seg_hex = 7'h21;
            4'hE:    w_seg_hex = 7'h06;
            default: w_seg_hex = 7'h0E;
        endcase
    end

    // Decimal point follows dp_mask even when the digit body is suppressed
    assign w_ss_show = {~w_sel_dp,
                        (w_sel_lz || (r_blink_phase && w_sel_blink)) ? 7'h7F : w_seg_hex};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_BLANK;
            r_presc       <= '0;
            r_idx         <= '0;
            r_blank_cnt   <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            ss            <= 8'hFF;
            enables       <= '1;
        end else begin
            if (w_tick) begin
                r_presc <= '0;
                if (r_blink_cnt == c_BLINK_LAST) begin
                    r_blink_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            case (r_state)
                S_BLANK: begin
                    ss      <= 8'hFF;
                    enables <= '1;
                    if (r_blank_cnt == c_BLANK_LAST) begin
                        r_state <= S_SHOW;
                        ss      <= w_ss_show;
                        enables <= w_en_show;
                    end else begin
                        r_blank_cnt <= r_blank_cnt + 1'b1;
                    end
                end
                S_SHOW: begin
                    if (w_tick) begin
                        r_state     <= S_BLANK;
                        r_idx       <= w_idx_next;
                        r_blank_cnt <= '0;
                        ss          <= 8'hFF;
                        enables     <= '1;
                    end else begin
                        ss      <= w_ss_show;
                        enables <= w_en_show;
                    end
                end
                default: begin
                    r_state <= S_BLANK;
                    ss      <= 8'hFF;
                    enables <= '1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_display_scanner
// Purpose  : Scoreboard bench for seg_display_scanner using a time-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_seg_display_scanner;

    localparam int ND    = 4;
    localparam int DIVP  = 8;
    localparam int BLANK = 2;
    localparam int BLINK = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] digits = 16'h0000;
    logic [3:0]  dp_mask = 4'h0;
    logic [3:0]  blink_mask = 4'h0;
    logic        blank_lz = 1'b0;
    logic [7:0]  ss;
    logic [3:0]  enables;

    int          checks = 0;
    int          errors = 0;
    int          n = 0;
    logic [11:0] sb_q[$];
    logic [11:0] exp_v;

    logic [15:0] r_dg;
    logic [3:0]  r_dp;
    logic [3:0]  r_bl;
    logic        r_lz;
    bit          r_rst;

    logic [7:0]  hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seg_display_scanner #(
        .NUM_DIGITS   (ND),
        .DIV          (DIVP),
        .BLANK_CYCLES (BLANK),
        .BLINK_TICKS  (BLINK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digits     (digits),
        .dp_mask    (dp_mask),
        .blink_mask (blink_mask),
        .blank_lz   (blank_lz),
        .ss         (ss),
        .enables    (enables)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] got_ss, input logic [3:0] got_en,
                         input logic [7:0] exp_ss, input logic [3:0] exp_en);
        checks++;
        if (got_ss !== exp_ss || got_en !== exp_en) begin
            errors++;
            $display("FAIL %s (cycle %0d): got ss=%h enables=%b, expected ss=%h enables=%b",
                     name, n, got_ss, got_en, exp_ss, exp_en);
        end
    endtask

    // Outputs after `cyc` clock edges since reset release. Each scan slot is
    // DIVP cycles long; the first BLANK cycles of every slot are dark.
    function automatic logic [11:0] model(input int cyc);
        int         slot;
        int         ofs;
        int         d;
        logic [7:0] s;
        logic [3:0] e;
        slot = cyc / DIVP;
        ofs  = cyc % DIVP;
        if (ofs < BLANK) return {8'hFF, 4'hF};
        d = slot % ND;
        s = hex_tbl[digits[4*d +: 4]];
        if ((d > 0 && blank_lz && (digits >> (4*d)) == 16'h0) ||
            (blink_mask[d] && ((slot / BLINK) % 2 == 1)))
            s[6:0] = 7'h7F;
        s[7] = ~dp_mask[d];
        e    = 4'hF;
        e[d] = 1'b0;
        return {s, e};
    endfunction

    // One clock of stimulus: inputs change at the falling edge, and the
    // expected result of the following rising edge is queued.
    task automatic step(input bit rst_val, input logic [15:0] dg, input logic [3:0] dp,
                        input logic [3:0] bl, input logic lz);
        @(negedge clk);
        digits     = dg;
        dp_mask    = dp;
        blink_mask = bl;
        blank_lz   = lz;
        if (rst_val && !reset) begin
            reset = 1'b1;
            #1;
            check("reset_immediate", ss, enables, 8'hFF, 4'hF);
        end
        reset = rst_val;
        if (rst_val) begin
            n = 0;
            sb_q.push_back({8'hFF, 4'hF});
        end else begin
            n++;
            sb_q.push_back(model(n));
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                exp_v = sb_q.pop_front();
                check("scan_output", ss, enables, exp_v[11:4], exp_v[3:0]);
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++)  step(1'b1, 16'h1234, 4'h0, 4'h0, 1'b0);
        for (int i = 0; i < 80; i++) step(1'b0, 16'h1234, 4'h0, 4'h0, 1'b0);
        for (int i = 0; i < 48; i++) step(1'b0, 16'h0050, 4'h0, 4'h0, 1'b1);
        for (int i = 0; i < 48; i++) step(1'b0, 16'h0050, 4'h0, 4'h0, 1'b0);

        step(1'b1, 16'h0000, 4'b0100, 4'h0, 1'b1);
        for (int i = 0; i < 48; i++) step(1'b0, 16'h0000, 4'b0100, 4'h0, 1'b1);

        // blink on digit 0, with a mid-SHOW digit change 8 -> 3
        step(1'b1, 16'h0008, 4'h0, 4'b0001, 1'b0);
        for (int i = 0; i < 5; i++)   step(1'b0, 16'h0008, 4'h0, 4'b0001, 1'b0);
        for (int i = 0; i < 3; i++)   step(1'b0, 16'h0003, 4'h0, 4'b0001, 1'b0);
        for (int i = 0; i < 140; i++) step(1'b0, 16'h0008, 4'h0, 4'b0001, 1'b0);

        // reset pulse while digit 2 is shown
        step(1'b1, 16'h1234, 4'h0, 4'h0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 16'h1234, 4'h0, 4'h0, 1'b0);
        step(1'b1, 16'h1234, 4'h0, 4'h0, 1'b0);
        step(1'b1, 16'h1234, 4'h0, 4'h0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 16'h1234, 4'h0, 4'h0, 1'b0);

        r_dg = 16'h0000;
        r_dp = 4'h0;
        r_bl = 4'h0;
        r_lz = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                r_dg = 16'($urandom);
                if ($urandom_range(0, 2) == 0) r_dg = r_dg & 16'h00FF;
                if ($urandom_range(0, 3) == 0) r_dg = r_dg & 16'h000F;
            end
            if ($urandom_range(0, 31) == 0) r_dp = 4'($urandom);
            if ($urandom_range(0, 31) == 0) r_bl = 4'($urandom);
            if ($urandom_range(0, 31) == 0) r_lz = 1'($urandom);
            r_rst = ($urandom_range(0, 199) == 0);
            step(r_rst, r_dg, r_dp, r_bl, r_lz);
        end

        @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_display_scanner.md
SEG_DISPLAY_SCANNER -- requirements
Module: seg_display_scanner

Interface
REQ-001 Parameters SHALL be:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- DIV, 500000, clk cycles per scan tick (>= BLANK_CYCLES+2).
- BLANK_CYCLES, 1000, anti-ghost dark cycles after each digit switch (>= 1).
- BLINK_TICKS, 50, scan ticks per blink half-period (>= 1).
REQ-002 Ports SHALL be:
- clk  in  1  single system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- digits  in  4*NUM_DIGITS  hex values; digits[3:0] is digit 0 (rightmost, least significant).
- dp_mask  in  NUM_DIGITS  bit i set = decimal point lit on digit i.
- blink_mask  in  NUM_DIGITS  bit i set = digit i blinks.
- blank_lz  in  1  leading-zero suppression enable.
- ss  out  8  segments {dp,g,f,e,d,c,b,a}, active-low, registered.
- enables  out  NUM_DIGITS  digit anodes, active-low, registered, at most one low.

Function
REQ-003 A free-running prescaler SHALL count 0..DIV-1 and wrap; a scan tick SHALL occur in the cycle it equals DIV-1.
REQ-004 A scan index idx SHALL hold 0..NUM_DIGITS-1 and wrap from NUM_DIGITS-1 to 0.
REQ-005 The FSM SHALL have states BLANK and SHOW.
REQ-006 In BLANK: enables all high and ss = 8'hFF; a counter SHALL count BLANK_CYCLES clocks, then move to SHOW.
REQ-007 In SHOW: enables[idx] SHALL be low, all others high; ss SHALL drive the decoded pattern for digit idx.
REQ-008 A scan tick in SHOW SHALL increment idx (with wrap), clear the blank counter and enter BLANK on the next clock.
REQ-009 A scan tick in BLANK SHALL be ignored (idx unchanged).
REQ-010 Hex decode (bits 6:0, active-low) SHALL be: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E (shown with dp off, bit 7=1).
REQ-011 ss[7] SHALL be 0 when dp_mask[idx]=1, else 1, regardless of blanking or blink state.
REQ-012 Digit i (i>0) SHALL be leading-zero blanked when blank_lz=1 and digits i..NUM_DIGITS-1 are all zero; ss[6:0] then = 7'h7F.
REQ-013 Digit 0 SHALL never be leading-zero blanked.
REQ-014 A blink counter SHALL count scan ticks; on the BLINK_TICKS-th tick it SHALL toggle blink_phase and restart.
REQ-015 When blink_phase=1 and blink_mask[idx]=1, ss[6:0] SHALL be 7'h7F; enables unaffected.
REQ-016 ss and enables SHALL be re-evaluated every clock from current inputs in SHOW; an input change SHALL appear on ss exactly one clock later.
REQ-017 Latency: enables SHALL change only on BLANK->SHOW or SHOW->BLANK transitions.

Reset
REQ-018 Asserting reset SHALL immediately force: prescaler=0, idx=0, blank counter=0, blink counter=0, blink_phase=0, state=BLANK, enables all high, ss=8'hFF.
REQ-019 After reset deasserts, enables[0] SHALL go low after exactly BLANK_CYCLES clocks.
REQ-020 Reset asserted mid-SHOW or mid-BLANK SHALL produce the REQ-018 state within the same cycle, with no enable glitch low.

Verification (NUM_DIGITS=4, DIV=8, BLANK_CYCLES=2, BLINK_TICKS=4)
REQ-021 digits=16'h1234, masks 0, blank_lz=0, release reset -> enables 1111 for 2 clocks, then 1110 with ss=99, then 1111 for 2 clocks, 1101 with ss=B0, then 1011 with ss=A4, 0111 with ss=F9, then wrap to 1110.
REQ-022 digits=16'h0050, blank_lz=1 -> digit3 and digit2 ss=FF, digit1 ss=92, digit0 ss=C0; with blank_lz=0, digit3 and digit2 ss=C0.
REQ-023 dp_mask=4'b0100, digits=16'h0000, blank_lz=1 -> digit2 ss=7F (segments off, dp lit), digit3 ss=FF, digit0 ss=C0.
REQ-024 blink_mask=4'b0001, digits=16'h0008 -> digit0 ss=80 for 4 scan ticks, FF for the next 4 scan ticks, repeating; other digits unaffected.
REQ-025 Change digits[3:0] from 8 to 3 mid-SHOW of digit 0 -> ss goes 80 to B0 one clock later; enables stay 1110.
REQ-026 Pulse reset during SHOW of digit 2 -> same cycle enables=1111, ss=FF; after release, digit 0 shown after 2 clocks.
